bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one iteration per clock. It sits directly upstream of the BCD digit adders and converts binary operands into packed BCD digits that the adders consume. Input and output use valid/ready handshakes, and there is one conversion in flight at a time.

Parameters:
- BIN_W, default 8: width of the binary input, must be 2 or more.
- DIGITS, default 3: number of BCD output digits. Requires 10^DIGITS > 2^BIN_W - 1; the integrator checks this, not the block.
- CNT_W, default 4: width of the iteration counter. Requires 2^CNT_W > BIN_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  bin_in holds a value to convert.
- in_ready  out  1  block can accept a value; high only in IDLE.
- bin_in  in  BIN_W  unsigned binary operand, sampled on the accept edge.
- bcd_out  out  4*DIGITS  packed BCD result, digit 0 = bits [3:0] (least significant).
- out_valid  out  1  bcd_out holds a result.
- out_ready  in  1  consumer takes the result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset, async and active-high:
  - state = IDLE, counter = 0, BCD register = 0, binary shift register = 0.
  - Outputs: bcd_out = 0, out_valid = 0, busy = 0, in_ready = 1.
- States and transitions:
  - IDLE: in_ready = 1. On an edge with in_valid=1: load bin_in into the binary shift register, clear the BCD register, counter = 0, go to SHIFT.
  - SHIFT: in_ready = 0. On each edge, perform one iteration:
    - Add 3 to every 4-bit digit whose value is 5 or more. All digits are evaluated in parallel from the pre-edge value.
    - Shift the concatenation {BCD, binary} left by 1.
    - Increment the counter.
    - On the edge where the counter reaches BIN_W-1, perform that final iteration and go to DONE.
  - DONE: out_valid = 1. bcd_out is held stable until out_ready=1 is sampled on an edge, then go to IDLE.
- Handshake rules:
  - Input transfer = in_valid & in_ready on an edge. in_valid while busy is ignored and no value is queued.
  - Output transfer = out_valid & out_ready on an edge. out_ready while not in DONE is ignored.
  - No accept in the same cycle as an output transfer; the next accept is possible on the edge after DONE is left.
- Latency:
  - out_valid rises exactly BIN_W clock edges after the accept edge.
  - Minimum throughput is one conversion per BIN_W+2 cycles.
- bcd_out is a registered output. It updates only on the final SHIFT edge and retains its value in IDLE until the next final SHIFT edge; intermediate iterations are not visible on bcd_out.
- Boundary conditions:
  - bin_in = 0 gives all-zero digits.
  - bin_in = 2^BIN_W-1 gives the correct full result with no overflow, given the parameter constraint.
  - Every emitted digit is 9 or less.
- Reset mid-conversion or while in DONE: outputs return to reset values immediately (asynchronously), the pending result is discarded, and no out_valid pulse follows.

Optional Feature:
- Macro BIN2BCD_SIGNED_EN.
- When defined:
  - bin_in is two's complement.
  - An extra output sign_out (1 bit) is added, registered and reset to 0.
  - On accept, the magnitude (|bin_in|, computed in BIN_W+1 bits so -2^(BIN_W-1) is exact) is loaded and sign_out latches bin_in[BIN_W-1].
  - Conversion runs BIN_W iterations on the magnitude, so latency is unchanged.
- When undefined: unsigned operation only, and no sign_out port.

Test Plan:
- Reset, then in_valid=1 with bin_in=8'd0: accepted on the first edge; out_valid high 8 edges later; bcd_out=12'h000.
- bin_in=8'd255 with out_ready=1: bcd_out=12'h255 with out_valid high for exactly one cycle; in_ready returns to 1 the next cycle.
- bin_in=8'd99, then 8'd100, back-to-back: results 12'h099 and 12'h100, in order; the second accept happens only when in_ready=1.
- Backpressure: bin_in=8'd37 with out_ready=0 for 5 cycles after out_valid: bcd_out=12'h037 held stable, busy=1, a second in_valid ignored; out_ready=1 completes the transfer and returns to IDLE.
- Assert rst for 1 cycle at iteration 4 of converting 8'd200: out_valid=0 and bcd_out=0 immediately; a new conversion of 8'd58 gives 12'h058.
- With BIN2BCD_SIGNED_EN defined:
  - bin_in=8'h80 gives sign_out=1, bcd_out=12'h128.
  - bin_in=8'hFF gives sign_out=1, bcd_out=12'h001.
  - bin_in=8'd127 gives sign_out=0, bcd_out=12'h127.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Define BIN2BCD_SIGNED_EN for two's-complement input with a separate sign_out.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign_out
`endif
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS+BIN_W-1:0] shifted;
  logic [BIN_W-1:0]      load_val;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_d;

  // Negating -2^(BIN_W-1) yields 2^(BIN_W-1), which is exact read as unsigned.
  always_comb begin
    load_val = bin_in;
    if (bin_in[BIN_W-1]) begin
      load_val = ~bin_in + BIN_W'(1);
    end
  end

  assign sign_out = sign_q;
`else
  assign load_val = bin_in;
`endif

  // All digits are corrected in parallel from the pre-edge value.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    res_d   = res_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d   = load_val;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
`ifdef BIN2BCD_SIGNED_EN
          sign_d  = bin_in[BIN_W-1];
`endif
        end
      end
      StShift: begin
        bcd_d = shifted[4*DIGITS+BIN_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          res_d   = shifted[4*DIGITS+BIN_W-1:BIN_W];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign bcd_out   = res_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random operands
// checked against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    bin_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
`ifdef BIN2BCD_SIGNED_EN
  logic                sign_out;
`endif

  int checks   = 0;
  int failures = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef BIN2BCD_SIGNED_EN
    ,
    .sign_out  (sign_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of the operand's magnitude by plain division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [BIN_W-1:0] v);
    logic [4*DIGITS-1:0] r;
    int m;
    m = int'(v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[BIN_W-1]) m = (1 << BIN_W) - int'(v);
`endif
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic run(input logic [BIN_W-1:0] v, input int stall);
    logic [4*DIGITS-1:0] exp;
    logic                ok;
    int                  n;
    exp = ref_bcd(v);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    bin_in    = v;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = BIN_W'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_while_busy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency_edges", 32'(n), 32'(BIN_W));
    chk("bcd_out", 32'(bcd_out), 32'(exp));
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_out[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    chk("digit_range", 32'(ok), 32'd1);
`ifdef BIN2BCD_SIGNED_EN
    chk("sign_out", 32'(sign_out), 32'(v[BIN_W-1]));
`endif
    for (int s = 0; s < stall; s++) begin
      in_valid = (s == 0);
      bin_in   = BIN_W'($urandom);
      @(posedge clk); #1;
      chk("hold_bcd", 32'(bcd_out), 32'(exp));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
    chk("idle_not_busy", 32'(busy), 32'd0);
    chk("bcd_retained", 32'(bcd_out), 32'(exp));
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run(8'd0, 0);
    run(8'd255, 0);
    run(8'd99, 0);
    run(8'd100, 0);
    run(8'd37, 5);

    // Reset in the middle of converting 200.
    in_valid = 1'b1;
    bin_in   = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef BIN2BCD_SIGNED_EN
    chk("midrst_sign", 32'(sign_out), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("no_valid_after_rst", 32'(pulses), 32'd0);
    run(8'd58, 0);

    run(8'h80, 0);
    run(8'hFF, 1);
    run(8'd127, 0);

    for (int k = 0; k < 16; k++) begin
      run(BIN_W'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
